pu_seq: RTL

//  Multi-cycle fetch/decode/execute/writeback sequencer for the 16-bit PU core.

---
 rtl/pu_seq.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/pu_seq.sv
// ---------------------------------------------------------------------------
// pu_seq
//   Multi-cycle fetch / decode / execute / writeback sequencer for the 16-bit
//   PU core. It fetches one instruction word at a time, holds it in ir for the
//   instruction decoder, and turns the decoder's write enable into a single
//   writeback-cycle pulse. It also provides run control (start, single-step),
//   stops on a halt instruction and counts retired instructions.
//
// Ports
//   clk, rst_n          clock (rising edge) and synchronous active-low reset
//   start               leave IDLE and begin fetching at pc
//   step_mode           1: pause after every retired instruction
//   step                in PAUSE: release the next instruction
//   imem_req/imem_addr  instruction fetch request and address (= pc)
//   imem_ack/imem_rdata fetch completion and the fetched word
//   ir                  instruction register, feeds the decoder
//   dec_we, dec_halt    decoder outputs for the current ir
//   rf_we               register-file write enable, gated to the WB cycle
//   pc                  program counter
//   state               FSM state code (IDLE=0 .. HALT=6)
//   busy, halted        run status decodes of state
//   retired             saturating count of retired instructions
//
// Fetch handshake (req/ack):
//   imem_req is high for every cycle the sequencer sits in FETCH, and
//   imem_addr holds pc unchanged for that whole time. The memory may take any
//   number of cycles; the transfer completes on the first rising edge where
//   imem_ack is 1, at which point imem_rdata is captured into ir and the
//   request drops in the following cycle. imem_ack outside FETCH is ignored.
//   There is no timeout, and reset abandons an outstanding fetch.
// ---------------------------------------------------------------------------
module pu_seq #(
    parameter int PC_W  = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             step_mode,
    input  logic             step,
    output logic             imem_req,
    output logic [PC_W-1:0]  imem_addr,
    input  logic             imem_ack,
    input  logic [15:0]      imem_rdata,
    output logic [15:0]      ir,
    input  logic             dec_we,
    input  logic             dec_halt,
    output logic             rf_we,
    output logic [PC_W-1:0]  pc,
    output logic [2:0]       state,
    output logic             busy,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_PAUSE  = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [PC_W-1:0]  PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t state_q;
    state_t state_d;

    // Datapath strobes produced by the next-state logic.
    logic ir_load;   // capture imem_rdata into ir
    logic retire;    // advance pc and the retired counter

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and datapath strobes
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        ir_load = 1'b0;
        retire  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (imem_ack) begin
                    ir_load = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                // A halt word never reaches WB, so it neither advances pc
                // nor counts as retired.
                state_d = dec_halt ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                state_d = S_WB;
            end
            S_WB: begin
                retire  = 1'b1;
                state_d = step_mode ? S_PAUSE : S_FETCH;
            end
            S_PAUSE: begin
                // Dropping step_mode while paused also releases the core.
                if (step || !step_mode) begin
                    state_d = S_FETCH;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath registers: ir, pc, retired
    // -----------------------------------------------------------------------
    // ir only loads on the fetch completion edge, so it stays constant from
    // DECODE through WB and the decoder outputs are stable per instruction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ir      <= '0;
            pc      <= '0;
            retired <= '0;
        end else begin
            if (ir_load) begin
                ir <= imem_rdata;
            end
            if (retire) begin
                pc <= pc + PC_ONE;               // wraps modulo 2^PC_W
                if (retired != CNT_MAX) begin
                    retired <= retired + CNT_ONE;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs: plain decodes of the registered state
    // -----------------------------------------------------------------------
    assign state     = state_q;
    assign imem_req  = (state_q == S_FETCH);
    assign imem_addr = pc;
    assign rf_we     = (state_q == S_WB) && dec_we;
    assign busy      = (state_q != S_IDLE) && (state_q != S_HALT);
    assign halted    = (state_q == S_HALT);

endmodule
